// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity type and supported prescale values.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic EVEN = 1'b0;
  localparam logic ODD  = 1'b1;

  localparam int PRESCALE_8  = 8;
  localparam int PRESCALE_16 = 16;
  localparam int PRESCALE_32 = 32;

endpackage

// File: rtl/uart_rx_data_sampling.sv
// Takes three samples around the middle of each bit and majority-votes them.
// The voted bit is stable from edge_cnt = Prescale/2+2 until the next bit's samples.
module uart_rx_data_sampling #(
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] edge_cnt,
  input  logic [PRESCALE_W-1:0] Prescale,
  output logic                  sampled_bit,
  output logic                  sample_done
);

  localparam logic [PRESCALE_W-1:0] ONE = 1;
  localparam logic [PRESCALE_W-1:0] TWO = 2;

  logic [PRESCALE_W-1:0] half;
  logic [2:0]            smp;

  assign half = Prescale >> 1;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      smp <= 3'b111;
    end else begin
      if (edge_cnt == half - ONE) smp[0] <= RX_IN;
      if (edge_cnt == half)       smp[1] <= RX_IN;
      if (edge_cnt == half + ONE) smp[2] <= RX_IN;
    end
  end

  assign sampled_bit = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);
  assign sample_done = (edge_cnt >= half + TWO);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled, majority-voted, LSB-first deserializer with optional parity
// and stop-bit checks; one-cycle data_valid / par_err / stp_err strobes at frame end.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int BCW = $clog2(DATA_WIDTH + 1);
  localparam logic [PRESCALE_W-1:0] ONE = 1;

  uart_state_e           state, state_nxt;
  logic [PRESCALE_W-1:0] edge_cnt, prescale_q;
  logic [BCW-1:0]        bit_cnt;
  logic                  par_en_q, par_typ_q, par_mismatch;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  smp_bit, smp_done, bit_end, start_det;

  uart_rx_data_sampling #(.PRESCALE_W(PRESCALE_W)) u_sampling (
    .CLK         (CLK),
    .RST         (RST),
    .RX_IN       (RX_IN),
    .edge_cnt    (edge_cnt),
    .Prescale    (prescale_q),
    .sampled_bit (smp_bit),
    .sample_done (smp_done)
  );

  assign bit_end   = smp_done && (edge_cnt == prescale_q - ONE);
  assign start_det = ((state == IDLE) && !RX_IN) || ((state == STOP) && bit_end && !RX_IN);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (!RX_IN) state_nxt = START;
      START:  if (bit_end) state_nxt = smp_bit ? IDLE : DATA;
      DATA:   if (bit_end && bit_cnt == BCW'(DATA_WIDTH - 1)) state_nxt = par_en_q ? PARITY : STOP;
      PARITY: if (bit_end) state_nxt = STOP;
      STOP:   if (bit_end) state_nxt = RX_IN ? IDLE : START;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt     <= '0;
      prescale_q   <= '0;
      bit_cnt      <= '0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      par_mismatch <= 1'b0;
      shift_reg    <= '0;
      P_DATA       <= '0;
      data_valid   <= 1'b0;
      par_err      <= 1'b0;
      stp_err      <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;

      // The falling edge seen in IDLE is itself edge 0 of the start bit.
      if (start_det) begin
        prescale_q   <= Prescale;
        par_en_q     <= PAR_EN;
        par_typ_q    <= PAR_TYP;
        par_mismatch <= 1'b0;
        bit_cnt      <= '0;
        edge_cnt     <= (state == IDLE) ? ONE : '0;
      end else if (state != IDLE) begin
        edge_cnt <= bit_end ? '0 : edge_cnt + ONE;
      end

      if (state == DATA && bit_end) begin
        shift_reg <= {smp_bit, shift_reg[DATA_WIDTH-1:1]};
        bit_cnt   <= bit_cnt + 1'b1;
      end

      if (state == PARITY && bit_end)
        par_mismatch <= smp_bit ^ (^shift_reg) ^ (par_typ_q == ODD);

      if (state == STOP && bit_end) begin
        stp_err <= ~smp_bit;
        par_err <= par_mismatch;
        if (smp_bit && !par_mismatch) begin
          P_DATA     <= shift_reg;
          data_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are serialized by the bench, expected strobes
// (cycle, flags, byte) are queued at frame start and matched when the DUT strobes.
module tb_uart_rx;
  import uart_pkg::*;

  typedef struct {
    int         cyc;
    logic [7:0] pd;
    logic       dv;
    logic       pe;
    logic       se;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [5:0] prescale = 6'd8;
  logic       par_en = 1'b0;
  logic       par_typ = 1'b0;
  logic [7:0] p_data;
  logic       data_valid, par_err, stp_err;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];
  logic [7:0] last_good = 8'h00;

  uart_rx #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
    .CLK        (clk),
    .RST        (rst_n),
    .RX_IN      (rx),
    .Prescale   (prescale),
    .PAR_EN     (par_en),
    .PAR_TYP    (par_typ),
    .P_DATA     (p_data),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Strobe monitor: every strobe cycle must match the oldest queued expectation.
  always @(negedge clk) begin
    if (data_valid || par_err || stp_err) begin
      if (sb.size() == 0) begin
        check("unexpected_strobe", {data_valid, par_err, stp_err}, 3'b000);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("strobe_cycle", cyc, e.cyc);
        check("data_valid", data_valid, e.dv);
        check("par_err", par_err, e.pe);
        check("stp_err", stp_err, e.se);
        check("p_data", p_data, e.pd);
      end
    end
  end

  task automatic drive_bit(input logic b, input int p);
    rx = b;
    repeat (p) @(negedge clk);
  endtask

  // Call at a negedge with the line idle; returns at the negedge after the stop bit.
  task automatic send_frame(input logic [7:0] d, input int p, input logic pen, input logic ptyp,
                            input logic bad_par, input logic stop_bit);
    exp_t e;
    logic pbit;
    int   nbits;
    prescale = 6'(p);
    par_en   = pen;
    par_typ  = ptyp;
    nbits    = pen ? 11 : 10;
    // Even parity: bit makes total ones even; odd type inverts it.
    pbit = (^d) ^ ptyp ^ bad_par;
    e.cyc = cyc + nbits * p;
    e.se  = ~stop_bit;
    e.pe  = pen & bad_par;
    e.dv  = ~e.se & ~e.pe;
    if (e.dv) last_good = d;
    e.pd  = last_good;
    sb.push_back(e);
    drive_bit(1'b0, p);
    for (int i = 0; i < 8; i++) drive_bit(d[i], p);
    if (pen) drive_bit(pbit, p);
    drive_bit(stop_bit, p);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    repeat (3) @(negedge clk);
    check("rst_p_data", p_data, 8'h00);
    check("rst_data_valid", data_valid, 1'b0);
    check("rst_par_err", par_err, 1'b0);
    check("rst_stp_err", stp_err, 1'b0);
    rst_n = 1'b1;
    idle(4);

    send_frame(8'hA5, 8, 1'b0, EVEN, 1'b0, 1'b1);
    idle(5);

    send_frame(8'h3C, 16, 1'b1, EVEN, 1'b0, 1'b1);
    idle(5);
    send_frame(8'h3C, 16, 1'b1, EVEN, 1'b1, 1'b1);
    idle(5);

    // Stop bit low: the line is still low at stop end, so a spurious start is rejected.
    send_frame(8'h01, 32, 1'b1, ODD, 1'b0, 1'b0);
    idle(70);

    prescale = 6'd8;
    par_en   = 1'b0;
    t0 = cyc;
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    while (cyc < t0 + 8) @(negedge clk);
    check("glitch_idle", int'(dut.state), int'(IDLE));
    idle(4);
    send_frame(8'h5A, 8, 1'b0, EVEN, 1'b0, 1'b1);
    idle(5);

    send_frame(8'h11, 16, 1'b0, EVEN, 1'b0, 1'b1);
    send_frame(8'hEE, 16, 1'b0, EVEN, 1'b0, 1'b1);
    idle(5);

    // Abort a frame during data bit 4 with reset.
    prescale = 6'd8;
    drive_bit(1'b0, 8);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 8);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_p_data", p_data, 8'h00);
    check("midrst_data_valid", data_valid, 1'b0);
    check("midrst_state", int'(dut.state), int'(IDLE));
    last_good = 8'h00;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(4);
    send_frame(8'hC3, 8, 1'b0, EVEN, 1'b0, 1'b1);
    idle(20);

    check("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
